// File: rtl/select_mask_pkg.sv
// Shared widths, FSM encodings, output word payload and popcount helper
// for the select mask loader.
package select_mask_pkg;

    localparam int unsigned NUM_WORDS  = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned CHAN_CNT_W = 12;
    localparam int unsigned POP_W      = 6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_INIT   = 2'd0;
    localparam state_t ST_IDLE   = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    // One mask word as it travels from the RAM to the AXIS output.
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } axis_word_t;

    // Number of enabled channels in one mask word.
    function automatic logic [POP_W-1:0] popcount_word(input logic [WORD_W-1:0] w);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            cnt = cnt + POP_W'(w[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mask_ram_64x32.sv
// Shadow mask storage: simple dual-port RAM with a 1-cycle registered read.
// A read that collides with a write to the same address returns the new data.
module mask_ram_64x32
    import select_mask_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [NUM_WORDS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, write-first on address collision
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/select_mask_loader.sv
// Shadow channel-enable mask with a word write port; a commit streams all 64
// words as one AXIS burst. Optional enabled-channel count is built when
// SELECT_MASK_CHAN_COUNT_EN is defined (otherwise chan_count is tied to 0).
module select_mask_loader
    import select_mask_pkg::*;
#(
    parameter logic INIT_VAL    = 1'b0,
    parameter logic AUTO_COMMIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    output logic                  wr_ready,
    output logic                  wr_drop,
    input  logic                  commit,
    output logic                  busy,
    output logic                  m_axis_select_tvalid,
    output logic [WORD_W-1:0]     m_axis_select_tdata,
    output logic                  m_axis_select_tlast,
    input  logic                  m_axis_select_tready,
    output logic [CHAN_CNT_W-1:0] chan_count
);

    state_t            state, state_nxt;
    logic              pending, pending_nxt;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic              ram_vld, ram_last;
    logic              out_vld, skid_vld;
    axis_word_t        out_q, skid_q, ram_word;
    logic              pop, room;
    logic [1:0]        occ;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata, ram_rdata;

    mask_ram_64x32 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign ram_word             = '{last: ram_last, data: ram_rdata};
    assign m_axis_select_tvalid = out_vld;
    assign m_axis_select_tdata  = out_q.data;
    assign m_axis_select_tlast  = out_q.last;

    // Next state, RAM port control and read issue; a read is only issued when
    // the output register plus skid can absorb it next cycle.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        ram_we      = 1'b0;
        ram_waddr   = wr_addr;
        ram_wdata   = wr_data;
        ram_re      = 1'b0;
        pop         = out_vld & m_axis_select_tready;
        occ         = 2'(out_vld) + 2'(skid_vld) + 2'(ram_vld);
        room        = (occ - 2'(pop)) < 2'd2;
        case (state)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_addr;
                ram_wdata = {WORD_W{INIT_VAL}};
                if (commit) pending_nxt = 1'b1;
                if (init_addr == LAST_ADDR) begin
                    if (AUTO_COMMIT | pending | commit) begin
                        state_nxt   = ST_STREAM;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                ram_we = wr_en;
                if (commit) begin
                    ram_re    = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ram_re = room & (~rd_done | pending);
                if (ram_re & rd_done) pending_nxt = 1'b0;
                if (commit) pending_nxt = 1'b1;
                if (pop & out_q.last & rd_done & ~pending & ~commit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // State, counters, flags and registered status outputs
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state     <= ST_INIT;
            pending   <= 1'b0;
            init_addr <= '0;
            rd_addr   <= '0;
            rd_done   <= 1'b0;
            ram_vld   <= 1'b0;
            ram_last  <= 1'b0;
            wr_drop   <= 1'b0;
            wr_ready  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == ST_INIT) init_addr <= init_addr + ADDR_W'(1);
            if (ram_re) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_done <= (rd_addr == LAST_ADDR);
            end
            ram_vld  <= ram_re;
            ram_last <= ram_re & (rd_addr == LAST_ADDR);
            if (wr_en & ~wr_ready) wr_drop <= 1'b1;
            wr_ready <= (state_nxt == ST_IDLE);
            busy     <= (state_nxt != ST_IDLE) | pending_nxt;
        end
    end

    // Output register with one-entry skid behind it to ride out the RAM latency
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            out_vld  <= 1'b0;
            out_q    <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else if (~out_vld | pop) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_q    <= skid_q;
                skid_vld <= ram_vld;
                if (ram_vld) skid_q <= ram_word;
            end else if (ram_vld) begin
                out_vld <= 1'b1;
                out_q   <= ram_word;
            end else begin
                out_vld    <= 1'b0;
                out_q.last <= 1'b0;
            end
        end else if (ram_vld) begin
            skid_vld <= 1'b1;
            skid_q   <= ram_word;
        end
    end

`ifdef SELECT_MASK_CHAN_COUNT_EN
    logic [CHAN_CNT_W-1:0] pop_acc, pop_sum_c;

    assign pop_sum_c = pop_acc + CHAN_CNT_W'(popcount_word(out_q.data));

    // Running popcount over accepted words, published on the tlast handshake
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            pop_acc    <= '0;
            chan_count <= '0;
        end else if (pop) begin
            if (out_q.last) begin
                chan_count <= pop_sum_c;
                pop_acc    <= '0;
            end else begin
                pop_acc <= pop_sum_c;
            end
        end
    end
`else
    assign chan_count = '0;
`endif

endmodule

// File: tb/tb_select_mask_loader.sv
// Scoreboard bench for select_mask_loader: expected words are queued when a
// burst is requested and compared as the DUT hands them off.
module tb_select_mask_loader;
    import select_mask_pkg::*;

    logic                  clk;
    logic                  sync_reset_n, rst1_n;
    logic                  wr_en, commit, tready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_W-1:0]     wr_data;
    logic                  wr_ready, wr_drop, busy, tvalid, tlast;
    logic [WORD_W-1:0]     tdata;
    logic [CHAN_CNT_W-1:0] chan_count;
    logic                  wr_ready1, wr_drop1, busy1, tvalid1, tlast1;
    logic [WORD_W-1:0]     tdata1;
    logic [CHAN_CNT_W-1:0] chan_count1;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    axis_word_t exp_q[$];
    axis_word_t exp1_q[$];
    logic [WORD_W-1:0] shadow [64];
    logic              hold_vld = 1'b0;
    logic [WORD_W-1:0] hold_data = '0;
    logic              hold_last = 1'b0;

    select_mask_loader #(.INIT_VAL(1'b0), .AUTO_COMMIT(1'b1)) u_dut (
        .clk(clk), .sync_reset_n(sync_reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_drop(wr_drop), .commit(commit), .busy(busy),
        .m_axis_select_tvalid(tvalid), .m_axis_select_tdata(tdata),
        .m_axis_select_tlast(tlast), .m_axis_select_tready(tready),
        .chan_count(chan_count)
    );

    select_mask_loader #(.INIT_VAL(1'b1), .AUTO_COMMIT(1'b1)) u_dut_ones (
        .clk(clk), .sync_reset_n(rst1_n),
        .wr_en(1'b0), .wr_addr(6'd0), .wr_data(32'd0),
        .wr_ready(wr_ready1), .wr_drop(wr_drop1), .commit(1'b0), .busy(busy1),
        .m_axis_select_tvalid(tvalid1), .m_axis_select_tdata(tdata1),
        .m_axis_select_tlast(tlast1), .m_axis_select_tready(1'b1),
        .chan_count(chan_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst();
        for (int i = 0; i < 64; i++) exp_q.push_back('{last: 1'(i == 63), data: shadow[i]});
    endtask

    function automatic logic [31:0] exp_chan();
`ifdef SELECT_MASK_CHAN_COUNT_EN
        int s = 0;
        for (int i = 0; i < 64; i++) s += $countones(shadow[i]);
        return 32'(s);
`else
        return 32'd0;
`endif
    endfunction

    task automatic wait_idle(input string tag, input bit rnd);
        int n = 0;
        while (busy && n < 2000) begin
            if (rnd) tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tready = 1'b1;
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    // Handshake monitor for the main DUT, including AXIS stall stability
    always @(negedge clk) begin
        if (!sync_reset_n) begin
            hold_vld <= 1'b0;
        end else begin
            if (hold_vld) begin
                check_eq("stall_valid", 32'(tvalid), 32'd1);
                check_eq("stall_data", tdata, hold_data);
                check_eq("stall_last", 32'(tlast), 32'(hold_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("word_data", tdata, exp_q[0].data);
                    check_eq("word_last", 32'(tlast), 32'(exp_q[0].last));
                    void'(exp_q.pop_front());
                end
                hs_count <= hs_count + 1;
            end
            hold_vld  <= tvalid && !tready;
            hold_data <= tdata;
            hold_last <= tlast;
        end
    end

    // Handshake monitor for the all-ones instance (tready tied high)
    always @(negedge clk) begin
        if (rst1_n && tvalid1) begin
            if (exp1_q.size() == 0) begin
                check_eq("ones_extra", 32'(exp1_q.size()), 32'd1);
            end else begin
                check_eq("ones_data", tdata1, exp1_q[0].data);
                check_eq("ones_last", 32'(tlast1), 32'(exp1_q[0].last));
                void'(exp1_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        bit seen, last_hs;
        sync_reset_n = 1'b0; rst1_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; tready = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_tvalid", 32'(tvalid), 32'd0);
        check_eq("rst_tlast", 32'(tlast), 32'd0);
        check_eq("rst_tdata", tdata, 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_chan_count", 32'(chan_count), 32'd0);

        // Test 1: auto-commit of the zero mask; all-ones instance alongside
        push_burst();
        for (int i = 0; i < 64; i++) exp1_q.push_back('{last: 1'(i == 63), data: 32'hFFFF_FFFF});
        sync_reset_n = 1'b1; rst1_n = 1'b1;
        wait_idle("t1_idle", 1'b0);
        check_eq("t1_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t1_chan_count", 32'(chan_count), exp_chan());
        check_eq("t1_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("t1_wr_drop", 32'(wr_drop), 32'd0);
        n = 0;
        while (busy1 && n < 300) begin tick(); n++; end
        check_eq("ones_idle", 32'(busy1), 32'd0);
        check_eq("ones_drained", 32'(exp1_q.size()), 32'd0);
`ifdef SELECT_MASK_CHAN_COUNT_EN
        check_eq("ones_chan_count", 32'(chan_count1), 32'd2048);
`else
        check_eq("ones_chan_count", 32'(chan_count1), 32'd0);
`endif
        rst1_n = 1'b0;

        // Test 2: two word writes, commit, latency of first tvalid
        write_word(0, 32'h0000_000F);
        write_word(63, 32'h8000_0000);
        commit = 1'b1;
        push_burst();
        tick();
        commit = 1'b0;
        check_eq("t2_tvalid_c1", 32'(tvalid), 32'd0);
        check_eq("t2_busy", 32'(busy), 32'd1);
        check_eq("t2_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        check_eq("t2_tvalid_c2", 32'(tvalid), 32'd1);
        wait_idle("t2_idle", 1'b0);
        check_eq("t2_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t2_chan_count", 32'(chan_count), exp_chan());

        // Test 2b: write and commit in the same cycle carry the new word
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'h1234_5678; commit = 1'b1;
        shadow[0] = 32'h1234_5678;
        push_burst();
        tick();
        wr_en = 1'b0; commit = 1'b0;
        wait_idle("t2b_idle", 1'b0);
        check_eq("t2b_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t2b_chan_count", 32'(chan_count), exp_chan());

        // Test 3: distinct words, random backpressure
        for (int i = 0; i < 64; i++) write_word(i, {8'(i), 8'hC3, 8'(63 - i), 8'(i * 3)});
        commit = 1'b1;
        push_burst();
        tick();
        commit = 1'b0;
        wait_idle("t3_idle", 1'b1);
        check_eq("t3_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t3_chan_count", 32'(chan_count), exp_chan());

        // Test 4: write during stream is dropped, shadow unchanged
        write_word(5, 32'hA5A5_A5A5);
        commit = 1'b1;
        push_burst();
        tick();
        commit = 1'b0;
        repeat (3) tick();
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        check_eq("t4_wr_drop", 32'(wr_drop), 32'd1);
        wait_idle("t4_idle_a", 1'b0);
        commit = 1'b1;
        push_burst();
        tick();
        commit = 1'b0;
        wait_idle("t4_idle_b", 1'b0);
        check_eq("t4_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t4_wr_drop_sticky", 32'(wr_drop), 32'd1);
        check_eq("t4_chan_count", 32'(chan_count), exp_chan());

        // Test 5: two commits during stream merge into one back-to-back burst
        commit = 1'b1;
        push_burst();
        push_burst();
        tick();
        commit = 1'b0;
        n = 0; seen = 1'b0;
        while (busy && n < 400) begin
            commit = (n == 5 || n == 15);
            last_hs = tvalid & tlast & tready;
            tick();
            n++;
            if (last_hs && !seen) begin
                seen = 1'b1;
                check_eq("t5_restart_valid", 32'(tvalid), 32'd1);
                check_eq("t5_restart_word0", tdata, shadow[0]);
            end
        end
        commit = 1'b0;
        check_eq("t5_seen_tlast", 32'(seen), 32'd1);
        check_eq("t5_idle", 32'(busy), 32'd0);
        check_eq("t5_drained", 32'(exp_q.size()), 32'd0);

        // Test 6: reset at word 30 abandons the burst; INIT repeats
        commit = 1'b1;
        push_burst();
        base = hs_count;
        tick();
        commit = 1'b0;
        n = 0;
        while ((hs_count - base) < 30 && n < 200) begin tick(); n++; end
        check_eq("t6_reach_w30", 32'(hs_count - base), 32'd30);
        check_eq("t6_w30_data", tdata, shadow[30]);
        sync_reset_n = 1'b0;
        exp_q.delete();
        tick();
        check_eq("t6_tvalid", 32'(tvalid), 32'd0);
        check_eq("t6_tlast", 32'(tlast), 32'd0);
        repeat (2) tick();
        check_eq("t6_busy", 32'(busy), 32'd1);
        check_eq("t6_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("t6_wr_drop", 32'(wr_drop), 32'd0);
        check_eq("t6_chan_count_rst", 32'(chan_count), 32'd0);
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        push_burst();
        sync_reset_n = 1'b1;
        wait_idle("t6_idle", 1'b0);
        check_eq("t6_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t6_chan_count", 32'(chan_count), exp_chan());
        repeat (4) tick();
        check_eq("t6_quiet", 32'(tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
